// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: interlock for load-use and mult/div hazards; tracks one in-flight mult/div op
//   clock, reset(active-low async)  : clocking
//   F_D_RS1/RS2/useRS2/RD/isMD      : decode-stage instruction fields
//   D_X_RD, D_X_ldMem               : execute-stage destination and load flag
//   md_ready, flush                 : mult/div done pulse, taken-branch kill
//   stall, bubble                   : hold PC+F/D, force nop into D/X
//   md_start/busy/rd/wb_en/err      : mult/div issue and tracking status
module hazard_stall_ctrl #(
  parameter int REG_W      = 5,
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] F_D_RS1,
  input  logic [REG_W-1:0] F_D_RS2,
  input  logic             F_D_useRS2,
  input  logic [REG_W-1:0] F_D_RD,
  input  logic             F_D_isMD,
  input  logic [REG_W-1:0] D_X_RD,
  input  logic             D_X_ldMem,
  input  logic             md_ready,
  input  logic             flush,
  output logic             stall,
  output logic             bubble,
  output logic             md_start,
  output logic             md_busy,
  output logic [REG_W-1:0] md_rd,
  output logic             md_wb_en,
  output logic             md_err
);
  typedef enum logic [1:0] {IDLE, MD_BUSY, MD_WB} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic loadUse, mdHazard, dxMatch, mdMatch;
  // register 0 is hardwired and never creates a dependency
  assign dxMatch = (D_X_RD != '0) & ((D_X_RD == F_D_RS1) | (F_D_useRS2 & (D_X_RD == F_D_RS2)));
  assign mdMatch = (md_rd != '0) & ((md_rd == F_D_RS1) | (F_D_useRS2 & (md_rd == F_D_RS2)));
  assign loadUse = D_X_ldMem & dxMatch;
  // RAW on the pending result, structural on a second mult/div, WAW on md_rd
  assign mdHazard = (state != IDLE) & (mdMatch | F_D_isMD | ((F_D_RD != '0) & (F_D_RD == md_rd)));
  // gating with reset keeps the combinational outputs at 0 while reset is held
  assign stall    = reset & ~flush & (loadUse | mdHazard);
  assign bubble   = reset & (stall | flush);
  assign md_busy  = state != IDLE;
  assign md_wb_en = state == MD_WB;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      md_rd    <= '0;
      md_start <= 1'b0;
      md_err   <= 1'b0;
    end else begin
      md_start <= 1'b0;
      case (state)
        IDLE: if (F_D_isMD & ~stall & ~flush) begin
          state    <= MD_BUSY;
          md_rd    <= F_D_RD;
          md_start <= 1'b1;
          cnt      <= '0;
        end
        MD_BUSY: begin
          cnt <= cnt + 1'b1;
          // a result arriving on the last allowed cycle still counts
          if (md_ready) state <= MD_WB;
          else if (cnt == CNT_W'(MD_TIMEOUT - 1)) begin
            md_err <= 1'b1;
            state  <= IDLE;
            md_rd  <= '0;
          end
        end
        MD_WB: begin
          state <= IDLE;
          md_rd <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;
  logic clock = 1'b0, reset = 1'b0;
  logic [4:0] F_D_RS1, F_D_RS2, F_D_RD, D_X_RD, md_rd;
  logic F_D_useRS2, F_D_isMD, D_X_ldMem, md_ready, flush;
  logic stall, bubble, md_start, md_busy, md_wb_en, md_err;
  logic [10:0] obs, e;
  logic [10:0] sb[$];
  int checks = 0, failures = 0;
  always #5 clock = ~clock;
  assign obs = {stall, bubble, md_start, md_busy, md_rd, md_wb_en, md_err};
  hazard_stall_ctrl dut (
    .clock(clock), .reset(reset), .F_D_RS1(F_D_RS1), .F_D_RS2(F_D_RS2), .F_D_useRS2(F_D_useRS2),
    .F_D_RD(F_D_RD), .F_D_isMD(F_D_isMD), .D_X_RD(D_X_RD), .D_X_ldMem(D_X_ldMem),
    .md_ready(md_ready), .flush(flush), .stall(stall), .bubble(bubble), .md_start(md_start),
    .md_busy(md_busy), .md_rd(md_rd), .md_wb_en(md_wb_en), .md_err(md_err)
  );
  function automatic logic [10:0] mk(input logic s, b, st, bz, input logic [4:0] rd, input logic wb, er);
    return {s, b, st, bz, rd, wb, er};
  endfunction
  task automatic drv(input logic [4:0] rs1, rs2, input logic u2, input logic [4:0] rd, input logic md,
                     input logic [4:0] dxrd, input logic ld, rdy, fl);
    F_D_RS1 = rs1; F_D_RS2 = rs2; F_D_useRS2 = u2; F_D_RD = rd; F_D_isMD = md;
    D_X_RD = dxrd; D_X_ldMem = ld; md_ready = rdy; flush = fl;
  endtask
  task automatic test_reset;
    drv(5, 0, 0, 0, 1, 5, 1, 0, 1);
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    #2 e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL reset got=%b exp=%b", obs, e); end
    @(negedge clock);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clock);
  endtask
  task automatic test_load_use;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin drv(5, 0, 0, 0, 0, 5, 1, 0, 0); sb.push_back(mk(1, 1, 0, 0, 0, 0, 0)); end
        1: begin drv(5, 0, 0, 0, 0, 5, 0, 0, 0); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0)); end
        default: begin drv(2, 6, 1, 0, 0, 6, 1, 0, 0); sb.push_back(mk(1, 1, 0, 0, 0, 0, 0)); end
      endcase
      #2 e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL load_use c%0d got=%b exp=%b", i, obs, e); end
      @(negedge clock);
    end
  endtask
  task automatic test_r0_unused;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
      else drv(3, 7, 0, 0, 0, 7, 1, 0, 0);
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      #2 e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL r0_unused c%0d got=%b exp=%b", i, obs, e); end
      @(negedge clock);
    end
  endtask
  task automatic test_md_issue_complete;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin drv(0, 0, 0, 9, 1, 0, 0, 0, 0); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0)); end
        1: begin drv(9, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back(mk(1, 1, 1, 1, 9, 0, 0)); end
        2: begin drv(0, 0, 0, 4, 1, 0, 0, 0, 0); sb.push_back(mk(1, 1, 0, 1, 9, 0, 0)); end
        3: begin drv(0, 0, 0, 9, 0, 0, 0, 0, 0); sb.push_back(mk(1, 1, 0, 1, 9, 0, 0)); end
        4: begin drv(9, 0, 0, 0, 0, 0, 0, 1, 0); sb.push_back(mk(1, 1, 0, 1, 9, 0, 0)); end
        5: begin drv(9, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back(mk(1, 1, 0, 1, 9, 1, 0)); end
        6: begin drv(9, 0, 0, 0, 0, 0, 0, 1, 0); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0)); end
        default: begin drv(9, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0)); end
      endcase
      #2 e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL md_issue c%0d got=%b exp=%b", i, obs, e); end
      @(negedge clock);
    end
  endtask
  task automatic test_timeout;
    for (int pass = 0; pass < 2; pass++) begin
      drv(0, 0, 0, 3, 1, 0, 0, 0, 0);
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      #2 e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL timeout_issue p%0d got=%b exp=%b", pass, obs, e); end
      @(negedge clock);
      for (int i = 0; i < 40; i++) begin
        drv(0, 0, 0, 0, 0, 0, 0, (pass == 1) && (i == 39), 0);
        sb.push_back(mk(0, 0, i == 0, 1, 3, 0, 0));
        #2 e = sb.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL timeout_busy p%0d cnt%0d got=%b exp=%b", pass, i, obs, e); end
        @(negedge clock);
      end
      drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
      sb.push_back(pass == 0 ? mk(0, 0, 0, 0, 0, 0, 1) : mk(0, 0, 0, 1, 3, 1, 0));
      #2 e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL timeout_end p%0d got=%b exp=%b", pass, obs, e); end
      @(negedge clock);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      sb.push_back(pass == 0 ? mk(0, 0, 0, 0, 0, 0, 1) : mk(0, 0, 0, 0, 0, 0, 0));
      #2 e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL timeout_after p%0d got=%b exp=%b", pass, obs, e); end
      if (pass == 0) begin
        #1 reset = 1'b0;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        #1 e = sb.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL err_clear got=%b exp=%b", obs, e); end
        @(negedge clock);
        reset = 1'b1;
      end
      @(negedge clock);
    end
  endtask
  task automatic test_flush;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin drv(5, 0, 0, 8, 1, 5, 1, 0, 1); sb.push_back(mk(0, 1, 0, 0, 0, 0, 0)); end
        1: begin drv(0, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0)); end
        2: begin drv(0, 0, 0, 12, 1, 0, 0, 0, 0); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0)); end
        3: begin drv(12, 0, 0, 0, 0, 0, 0, 0, 1); sb.push_back(mk(0, 1, 1, 1, 12, 0, 0)); end
        default: begin drv(12, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back(mk(1, 1, 0, 1, 12, 0, 0)); end
      endcase
      #2 e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL flush c%0d got=%b exp=%b", i, obs, e); end
      if (i < 4) @(negedge clock);
    end
    #1 reset = 1'b0;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    #1 e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL async_reset got=%b exp=%b", obs, e); end
    @(negedge clock);
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    #2 e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL post_reset got=%b exp=%b", obs, e); end
    @(negedge clock);
  endtask
  initial begin
    test_reset;
    test_load_use;
    test_r0_unused;
    test_md_issue_complete;
    test_timeout;
    test_flush;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
